// File: rtl/msk_skinny_round_seq_pkg.sv
// Shared types and helpers for the masked SKINNY round sequencer.
// Holds the FSM encoding, the round-constant LFSR step and the block width.
package skinny_pkg;
    localparam int              RC_W     = 6;
    localparam logic [RC_W-1:0] RC_INIT  = 6'h00;
    localparam int              BLK_BITS = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRND,
        ST_PH,
        ST_COMMIT,
        ST_LAST
    } seq_state_e;

    // The round-constant update is an affine LFSR, so all-zero is a legal seed.
    function automatic logic [RC_W-1:0] lfsr6(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction
endpackage

// File: rtl/msk_skinny_round_seq_if.sv
// Host and PRNG handshake bundle for the masked SKINNY sequencer.
// Share vectors interleave the D shares of each bit: bit b share s sits at b*D+s.
interface msk_skinny_round_seq_if #(
    parameter int D    = 2,
    parameter int RNDW = 64
);
    import skinny_pkg::*;

    logic                    start;
    logic [BLK_BITS*D-1:0]   pt_i;
    logic                    busy;
    logic                    done;
    logic [BLK_BITS*D-1:0]   ct_o;
    logic                    rnd_valid;
    logic                    rnd_ready;
    logic [RNDW-1:0]         rnd_i;

    modport master (
        output start, pt_i, rnd_valid, rnd_i,
        input  busy, done, ct_o, rnd_ready
    );
    modport slave (
        input  start, pt_i, rnd_valid, rnd_i,
        output busy, done, ct_o, rnd_ready
    );
endinterface

// File: rtl/msk_skinny_phase_gen.sv
// Borrowed-Time phase generator: walks NPH one-hot phase enables while active,
// and raises the clear strobe whenever no phase is running.
module msk_skinny_phase_gen #(
    parameter int NPH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           act_i,
    output logic [NPH-1:0] en_ph_o,
    output logic           bt_clear_o,
    output logic           last_o
);
    localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;

    logic [PW-1:0] ph_q, ph_d;

    // Counter parks at zero outside the phase window so every round starts at phase 0.
    always_comb begin
        ph_d = '0;
        if (act_i && !last_o) ph_d = ph_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ph_q <= '0;
        else     ph_q <= ph_d;
    end

    for (genvar k = 0; k < NPH; k++) begin : g_ph
        assign en_ph_o[k] = act_i && (ph_q == PW'(k));
    end

    assign last_o     = act_i && (ph_q == PW'(NPH - 1));
    assign bt_clear_o = !act_i;
endmodule

// File: rtl/msk_skinny_round_seq.sv
// Masked SKINNY round sequencer: owns the D-share state register and drives
// phase enables, clear strobe, key gating and round constant for the datapath.
module msk_skinny_round_seq
    import skinny_pkg::*;
#(
    parameter int D    = 2,
    parameter int NR   = 40,
    parameter int NPH  = 4,
    parameter int RNDW = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    msk_skinny_round_seq_if.slave hif,
    output logic [RNDW-1:0]       rnd_o,
    output logic [BLK_BITS*D-1:0] state_o,
    input  logic [BLK_BITS*D-1:0] round_i,
    output logic [NPH-1:0]        en_ph,
    output logic                  bt_clear,
    output logic                  key_en,
    output logic [RC_W-1:0]       rc_o
);
    localparam int SW = BLK_BITS * D;
    localparam int CW = $clog2(NR + 1);

    seq_state_e      fsm_q, fsm_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [RNDW-1:0] rnd_q, rnd_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ph_act, ph_last;

    msk_skinny_phase_gen #(.NPH(NPH)) u_ph (
        .clk        (clk),
        .rst        (rst),
        .act_i      (ph_act),
        .en_ph_o    (en_ph),
        .bt_clear_o (bt_clear),
        .last_o     (ph_last)
    );

    // Reset wipes share and randomness registers so an abort leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
            sh_q  <= '0;
            rnd_q <= '0;
            rc_q  <= RC_INIT;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            sh_q  <= sh_d;
            rnd_q <= rnd_d;
            rc_q  <= rc_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        sh_d  = sh_q;
        rnd_d = rnd_q;
        rc_d  = rc_q;
        cnt_d = cnt_q;
        case (fsm_q)
            ST_IDLE:   if (hif.start) fsm_d = ST_LOAD;
            ST_LOAD: begin
                sh_d  = hif.pt_i;
                cnt_d = '0;
                rc_d  = RC_INIT;
                fsm_d = ST_WRND;
            end
            // Only place the sequence may stall: a round never starts without its randomness.
            ST_WRND: begin
                if (hif.rnd_valid) begin
                    rnd_d = hif.rnd_i;
                    rc_d  = lfsr6(rc_q);
                    fsm_d = ST_PH;
                end
            end
            ST_PH:     if (ph_last) fsm_d = ST_COMMIT;
            ST_COMMIT: begin
                sh_d  = round_i;
                cnt_d = cnt_q + CW'(1);
                fsm_d = (cnt_q == CW'(NR - 1)) ? ST_LAST : ST_WRND;
            end
            ST_LAST:   fsm_d = ST_IDLE;
            default:   fsm_d = ST_IDLE;
        endcase
    end

    assign ph_act        = (fsm_q == ST_PH);
    assign hif.rnd_ready = (fsm_q == ST_WRND) && hif.rnd_valid;
    assign hif.busy      = (fsm_q != ST_IDLE);
    assign hif.done      = (fsm_q == ST_LAST);
    assign hif.ct_o      = hif.done ? sh_q : '0;
    assign key_en        = (fsm_q == ST_COMMIT);
    assign rnd_o         = rnd_q;
    assign state_o       = sh_q;
    assign rc_o          = rc_q;
endmodule

// File: tb/tb_msk_skinny_round_seq.sv
// Self-checking bench: emulates a masked round datapath around the sequencer and
// checks every output each cycle against a position-in-encryption model.
module tb_msk_skinny_round_seq;
    import skinny_pkg::*;

    localparam int D = 2, NR = 40, NPH = 4, RNDW = 64;
    localparam int SW = 128 * D;
    localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT = 2, S_PH0 = 3;
    localparam int S_COMMIT = NPH + 3, S_LAST = NPH + 4;
    localparam int LAT = 1 + NR * (NPH + 2) + 1;
    localparam logic [127:0] KEY = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RNDW-1:0] rnd_o;
    logic [SW-1:0]   state_o;
    logic [SW-1:0]   round_i = '0;
    logic [NPH-1:0]  en_ph;
    logic            bt_clear, key_en;
    logic [5:0]      rc_o;

    msk_skinny_round_seq_if #(.D(D), .RNDW(RNDW)) hif ();

    msk_skinny_round_seq #(.D(D), .NR(NR), .NPH(NPH), .RNDW(RNDW)) dut (
        .clk(clk), .rst(rst), .hif(hif), .rnd_o(rnd_o), .state_o(state_o),
        .round_i(round_i), .en_ph(en_ph), .bt_clear(bt_clear), .key_en(key_en), .rc_o(rc_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, rv_mode = 0;
    int done_cnt = 0, last_done = -1;
    logic [5:0] rc_tab [6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] unmask(input logic [SW-1:0] v);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 128; b++)
            for (int s = 0; s < D; s++) r[b] = r[b] ^ v[b*D+s];
        return r;
    endfunction

    function automatic logic [SW-1:0] mask(input logic [127:0] x);
        logic [SW-1:0] v;
        logic acc;
        v = '0;
        for (int b = 0; b < 128; b++) begin
            acc = x[b];
            for (int s = 1; s < D; s++) begin
                v[b*D+s] = 1'($urandom_range(1));
                acc      = acc ^ v[b*D+s];
            end
            v[b*D] = acc;
        end
        return v;
    endfunction

    function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
        return (x << n) | (x >> (128 - n));
    endfunction

    // Toy nonlinear round standing in for the external SKINNY datapath.
    function automatic logic [127:0] rf(input logic [127:0] x, input logic [5:0] rc, input logic ken);
        return rotl(x, 1) ^ (rotl(x, 8) & rotl(x, 3)) ^ {122'b0, rc} ^ (ken ? KEY : 128'b0);
    endfunction

    function automatic logic [5:0] next_rc(input logic [5:0] rc);
        int v;
        v = int'(rc);
        return 6'(((v * 2) & 63) | (((v >> 5) ^ (v >> 4) ^ 1) & 1));
    endfunction

    function automatic logic [127:0] golden(input logic [127:0] pt);
        logic [127:0] x;
        logic [5:0]   rc;
        x  = pt;
        rc = 6'h00;
        for (int r = 0; r < NR; r++) begin
            rc = next_rc(rc);
            x  = rf(x, rc, 1'b1);
        end
        return x;
    endfunction

    // Datapath emulator: recombine, apply round, re-share with fresh masks.
    always @(posedge clk) begin
        #2;
        round_i = mask(rf(unmask(state_o), rc_o, key_en));
    end

    int              m_step = 0, m_round = 0, m_stall = 0, m_t0 = 0;
    logic [5:0]      m_rc = '0;
    logic [RNDW-1:0] m_rnd = '0;
    logic [SW-1:0]   m_sh = '0;
    logic [127:0]    m_gold = '0;

    // Compare process: check this cycle's outputs, then advance the model on this cycle's inputs.
    always @(negedge clk) begin
        bit             ph;
        logic [NPH-1:0] e_ph;
        ph   = (m_step >= S_PH0) && (m_step < S_COMMIT);
        e_ph = ph ? (NPH'(1) << (m_step - S_PH0)) : '0;
        chk("busy", hif.busy, m_step != S_IDLE);
        chk("done", hif.done, m_step == S_LAST);
        chk("rnd_ready", hif.rnd_ready, (m_step == S_WAIT) && hif.rnd_valid);
        chk("en_ph", en_ph, e_ph);
        chk("bt_clear", bt_clear, !ph);
        chk("key_en", key_en, m_step == S_COMMIT);
        chk("rc_o", rc_o, m_rc);
        chk("rnd_o", rnd_o, m_rnd);
        chk("state_o", state_o, m_sh);
        chk("ct_o", hif.ct_o, (m_step == S_LAST) ? m_sh : '0);
        if (m_step == S_PH0 && m_round < 6) chk("rc_pinned", rc_o, rc_tab[m_round]);
        if (m_step == S_LAST) begin
            chk("ct_unmasked", unmask(hif.ct_o), m_gold);
            chk("latency", cyc - m_t0, LAT + m_stall);
        end
        if (hif.done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (rst) begin
            m_step = S_IDLE; m_sh = '0; m_rnd = '0; m_rc = '0;
        end else if (m_step == S_IDLE) begin
            if (hif.start) begin
                m_step = S_LOAD; m_t0 = cyc; m_stall = 0;
            end
        end else if (m_step == S_LOAD) begin
            m_sh = hif.pt_i; m_gold = golden(unmask(hif.pt_i));
            m_rc = '0; m_round = 0; m_step = S_WAIT;
        end else if (m_step == S_WAIT) begin
            if (hif.rnd_valid) begin
                m_rnd = hif.rnd_i; m_rc = next_rc(m_rc); m_step = S_PH0;
            end else m_stall++;
        end else if (m_step < S_COMMIT) begin
            m_step++;
        end else if (m_step == S_COMMIT) begin
            m_sh = round_i; m_round++;
            m_step = (m_round == NR) ? S_LAST : S_WAIT;
        end else m_step = S_IDLE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rv_mode)
            0:       hif.rnd_valid = 1'b1;
            1:       hif.rnd_valid = ($urandom_range(99) < 70);
            default: hif.rnd_valid = 1'b0;
        endcase
        hif.rnd_i = {$urandom, $urandom};
    endtask

    task automatic start_run(input logic [127:0] pt, output int c0);
        hif.pt_i  = mask(pt);
        hif.start = 1'b1;
        c0        = cyc;
        tick();
        hif.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n0, k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < bound) begin
            tick();
            k++;
        end
        total++;
        if (done_cnt == n0) begin
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    initial begin
        int c0, nd;
        logic [127:0] pt0, pt1;
        hif.start = 1'b0; hif.pt_i = '0; hif.rnd_valid = 1'b0; hif.rnd_i = '0;
        pt0 = 128'h00112233_44556677_8899aabb_ccddeeff;
        pt1 = 128'hdeadbeef_01234567_89abcdef_fedcba98;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", hif.busy, 0);
        chk("rst_done", hif.done, 0);
        chk("rst_bt_clear", bt_clear, 1);
        chk("rst_en_ph", en_ph, 0);
        chk("rst_rc", rc_o, 0);
        chk("rst_ct", hif.ct_o, 0);

        // Nominal run with randomness always available.
        start_run(pt0, c0);
        wait_done(400);
        chk("lat_nominal", last_done - c0, 242);

        // PRNG drops for 5 cycles exactly at round 3's randomness request.
        tick();
        start_run(pt0, c0);
        repeat (12) tick();
        rv_mode = 2;
        tick();
        repeat (4) tick();
        rv_mode = 0;
        tick();
        wait_done(400);
        chk("lat_stall", last_done - c0, 247);

        // Abort mid-run, then a clean rerun.
        tick();
        nd = done_cnt;
        start_run(pt1, c0);
        repeat (99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", hif.busy, 0);
        chk("abort_state", state_o, 0);
        chk("abort_rnd", rnd_o, 0);
        repeat (5) tick();
        chk("abort_no_done", done_cnt - nd, 0);
        start_run(pt1, c0);
        wait_done(400);

        // Start held through the done cycle: ignored there, accepted from IDLE next cycle.
        tick();
        start_run(pt0, c0);
        hif.start = 1'b1;
        wait_done(400);
        chk("restart_idle_gap", hif.busy, 0);
        tick();
        hif.start = 1'b0;
        chk("restart_load", hif.busy, 1);
        wait_done(400);

        // Random plaintexts with a bursty PRNG.
        rv_mode = 1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(3)) tick();
            start_run({$urandom, $urandom, $urandom, $urandom}, c0);
            wait_done(1500);
        end

        // Same plaintext under fresh share splits must give the same unmasked ciphertext.
        for (int i = 0; i < 12; i++) begin
            rv_mode = i % 2;
            tick();
            start_run(pt1, c0);
            wait_done(1500);
        end

        rv_mode = 0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
